xadac_vmem: RTL

//  Single-beat AXI subordinate backed by a vector-wide SRAM array. It is the responder for the xadac AW/W/B and AR/R master ports.

---
 rtl/xadac_vmem.sv | 130 +++++++++++++
 1 files changed

// File: rtl/xadac_vmem.sv
// Single-beat AXI subordinate over a DataWidth-wide SRAM: independent AW/W holding
// slots feed a write commit, and a one-deep R register allows one read per cycle.
module xadac_vmem #(
  parameter int IdWidth   = 4,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 256,
  parameter int Depth     = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [IdWidth-1:0]     aw_id,
  input  logic [AddrWidth-1:0]   aw_addr,
  input  logic                   aw_valid,
  output logic                   aw_ready,
  input  logic [DataWidth-1:0]   w_data,
  input  logic [DataWidth/8-1:0] w_strb,
  input  logic                   w_valid,
  output logic                   w_ready,
  output logic [IdWidth-1:0]     b_id,
  output logic [1:0]             b_resp,
  output logic                   b_valid,
  input  logic                   b_ready,
  input  logic [IdWidth-1:0]     ar_id,
  input  logic [AddrWidth-1:0]   ar_addr,
  input  logic                   ar_valid,
  output logic                   ar_ready,
  output logic [IdWidth-1:0]     r_id,
  output logic [DataWidth-1:0]   r_data,
  output logic [1:0]             r_resp,
  output logic                   r_valid,
  input  logic                   r_ready
);

  localparam int StrbW = DataWidth / 8;
  localparam int OffW  = $clog2(StrbW);
  localparam int IdxW  = $clog2(Depth);
  localparam logic [AddrWidth-1:0] MemBytes = AddrWidth'(Depth * StrbW);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid outputs stay asserted with stable payload until that edge.

  logic                 aw_full;
  logic                 w_full;
  logic [IdWidth-1:0]   aw_id_q;
  logic [AddrWidth-1:0] aw_addr_q;
  logic [DataWidth-1:0] w_data_q;
  logic [StrbW-1:0]     w_strb_q;
  logic [DataWidth-1:0] mem [Depth];

  logic            aw_fire;
  logic            w_fire;
  logic            ar_fire;
  logic            commit;
  logic            aw_in_range;
  logic            ar_in_range;
  logic [IdxW-1:0] aw_idx;
  logic [IdxW-1:0] ar_idx;

  assign aw_ready    = !aw_full && !b_valid;
  assign w_ready     = !w_full && !b_valid;
  assign ar_ready    = !r_valid || r_ready;
  assign aw_fire     = aw_valid && aw_ready;
  assign w_fire      = w_valid && w_ready;
  assign ar_fire     = ar_valid && ar_ready;
  assign commit      = aw_full && w_full;
  assign aw_in_range = aw_addr_q < MemBytes;
  assign ar_in_range = ar_addr < MemBytes;
  assign aw_idx      = aw_addr_q[OffW +: IdxW];
  assign ar_idx      = ar_addr[OffW +: IdxW];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      b_valid <= 1'b0;
      b_id    <= '0;
      b_resp  <= RespOkay;
    end else if (commit) begin
      // b_valid is necessarily low here: slots only fill while no response is pending.
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      b_valid <= 1'b1;
      b_id    <= aw_id_q;
      b_resp  <= aw_in_range ? RespOkay : RespSlverr;
    end else begin
      if (b_valid && b_ready) b_valid <= 1'b0;
      if (aw_fire)            aw_full <= 1'b1;
      if (w_fire)             w_full  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_fire) begin
      aw_id_q   <= aw_id;
      aw_addr_q <= aw_addr;
    end
    if (w_fire) begin
      w_data_q <= w_data;
      w_strb_q <= w_strb;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && commit && aw_in_range) begin
      for (int b = 0; b < StrbW; b++) begin
        if (w_strb_q[b]) mem[aw_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
      end
    end
  end

  // The array read uses the pre-edge contents, so a same-edge commit is seen by the next read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_data  <= '0;
      r_resp  <= RespOkay;
    end else if (ar_fire) begin
      r_valid <= 1'b1;
      r_id    <= ar_id;
      r_data  <= ar_in_range ? mem[ar_idx] : '0;
      r_resp  <= ar_in_range ? RespOkay : RespSlverr;
    end else if (r_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
